// File: rtl/sdram_cmd_mon_pkg.sv
// Shared definitions for the SDRAM command-bus monitor.
//   cmd_e      : decoded command, encoded as {ras_n,cas_n,we_n} (cs_n=1 folds into CmdNop)
//   state_e    : init-sequence FSM states
//   tmr_src_e  : which command last loaded the shared post-command timer
//   Err*       : bit positions inside err_vec
//   cmd_decode : raw {cs_n,ras_n,cas_n,we_n} -> cmd_e
package sdram_cmd_mon_pkg;

  typedef enum logic [2:0] {
    CmdMrs  = 3'b000,
    CmdAref = 3'b001,
    CmdPre  = 3'b010,
    CmdAct  = 3'b011,
    CmdWr   = 3'b100,
    CmdRd   = 3'b101,
    CmdBst  = 3'b110,
    CmdNop  = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    StWait,
    StPre,
    StAref,
    StMrs,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    TmrNone,
    TmrRp,
    TmrRfc,
    TmrMrd
  } tmr_src_e;

  localparam int unsigned ErrInitSeq  = 0;
  localparam int unsigned ErrTrp      = 1;
  localparam int unsigned ErrTrfc     = 2;
  localparam int unsigned ErrTmrd     = 3;
  localparam int unsigned ErrArefLate = 4;
  localparam int unsigned ErrBank     = 5;
  localparam int unsigned ErrW        = 6;

  // A deselected device (cs_n=1) sees nothing, which is the same as a NOP.
  function automatic cmd_e cmd_decode(input logic [3:0] raw);
    if (raw[3]) begin
      return CmdNop;
    end
    return cmd_e'(raw[2:0]);
  endfunction

endpackage

// File: rtl/sdram_cmd_mon_if.sv
// SDRAM command bus as seen on the pins.
//   sdram_cmd  [3:0]  {cs_n,ras_n,cas_n,we_n}
//   sdram_ba   [1:0]  bank address
//   sdram_addr [12:0] row/col/mode address; bit 10 = all-banks on PRECHARGE
// Modports: master (controller side, drives), slave (monitor/device side, observes).
interface sdram_cmd_mon_if;

  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  modport master (
    output sdram_cmd,
    output sdram_ba,
    output sdram_addr
  );

  modport slave (
    input sdram_cmd,
    input sdram_ba,
    input sdram_addr
  );

endinterface

// File: rtl/sdram_cmd_mon_bank_tracker.sv
// Open-bank map for the SDRAM command monitor. Only exists when SDRAM_MON_BANK_CHK_EN is
// defined; the default build has no bank tracking at all.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_cmd        : decoded current command
//   i_ba         : bank address of the current command
//   i_a10        : addr[10], all-banks flag on PRECHARGE
//   o_viol       : current command is illegal for the present open map (combinational)
`ifdef SDRAM_MON_BANK_CHK_EN
module sdram_cmd_mon_bank_tracker
  import sdram_cmd_mon_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  cmd_e       i_cmd,
  input  logic [1:0] i_ba,
  input  logic       i_a10,
  output logic       o_viol
);

  logic [3:0] r_bank_open;

  always_comb begin
    o_viol = 1'b0;
    case (i_cmd)
      CmdAct:          o_viol = r_bank_open[i_ba];
      CmdRd, CmdWr:    o_viol = !r_bank_open[i_ba];
      CmdAref, CmdMrs: o_viol = |r_bank_open;
      default:         o_viol = 1'b0;
    endcase
  end

  // The map follows the command even when it was a violation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bank_open <= 4'b0000;
    end else begin
      case (i_cmd)
        CmdAct: r_bank_open[i_ba] <= 1'b1;
        CmdPre: begin
          if (i_a10) begin
            r_bank_open <= 4'b0000;
          end else begin
            r_bank_open[i_ba] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/sdram_cmd_mon.sv
// SDRAM command-bus monitor. Decodes the command bus, follows the power-up init sequence
// (wait, PRECHARGE-all, AUTO_REFRESH x INIT_AREF, MODE_REG_SET), checks tRP/tRFC/tMRD and
// the refresh interval, and keeps sticky error flags.
// Optional: define SDRAM_MON_BANK_CHK_EN to add open-bank tracking (err_vec[5]);
// otherwise err_vec[5] is always 0.
//   i_sys_clk, i_sys_rst : command clock, asynchronous active-high reset
//   i_sdram              : command bus (slave modport)
//   i_err_clr            : synchronous clear of o_err_vec and o_aref_cnt
//   o_init_done          : init MRS accepted, monitor in RUN
//   o_mode_reg           : address captured on the init MRS
//   o_aref_cnt           : AUTO_REFRESH count in RUN, saturating
//   o_err_vec            : sticky [0]init_seq [1]tRP [2]tRFC [3]tMRD [4]aref_late [5]bank
//   o_err_pulse          : one-cycle pulse when any error bit newly sets
module sdram_cmd_mon
  import sdram_cmd_mon_pkg::*;
#(
  parameter int unsigned INIT_WAIT = 20000,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_RFC     = 7,
  parameter int unsigned T_MRD     = 3,
  parameter int unsigned INIT_AREF = 2,
  parameter int unsigned AREF_MAX  = 750
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  sdram_cmd_mon_if.slave       i_sdram,
  input  logic                 i_err_clr,
  output logic                 o_init_done,
  output logic [12:0]          o_mode_reg,
  output logic [15:0]          o_aref_cnt,
  output logic [ErrW-1:0]      o_err_vec,
  output logic                 o_err_pulse
);

  localparam int unsigned WaitW = $clog2(INIT_WAIT + 1);
  localparam int unsigned ArW   = $clog2(INIT_AREF + 1);
  localparam int unsigned AIntW = $clog2(AREF_MAX + 1);
  localparam int unsigned TMaxA = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int unsigned TMax  = (TMaxA > T_MRD) ? TMaxA : T_MRD;
  localparam int unsigned TmrW  = $clog2(TMax + 1);

  cmd_e              w_cmd;
  logic              w_nonnop;
  logic              w_a10;
  logic [ErrW-1:0]   w_err_new;
  logic [ErrW-1:0]   w_err_rise;

  state_e            r_state;
  logic [WaitW-1:0]  r_wait;
  logic [ArW-1:0]    r_init_aref;
  logic [12:0]       r_mode_reg;
  logic              r_init_done;
  logic [TmrW-1:0]   r_tmr;
  tmr_src_e          r_tmr_src;
  logic [AIntW-1:0]  r_aref_int;
  logic [15:0]       r_aref_cnt;
  logic [ErrW-1:0]   r_err_vec;
  logic              r_err_pulse;

  assign w_cmd    = cmd_decode(i_sdram.sdram_cmd);
  assign w_nonnop = (w_cmd != CmdNop);
  assign w_a10    = i_sdram.sdram_addr[10];

`ifdef SDRAM_MON_BANK_CHK_EN
  logic w_bank_viol;

  sdram_cmd_mon_bank_tracker u_bank_tracker (
    .i_clk  (i_sys_clk),
    .i_rst  (i_sys_rst),
    .i_cmd  (w_cmd),
    .i_ba   (i_sdram.sdram_ba),
    .i_a10  (w_a10),
    .o_viol (w_bank_viol)
  );
`else
  logic w_unused_ba;
  assign w_unused_ba = ^i_sdram.sdram_ba;
`endif

  // Errors raised by the current command, checked against state before this edge.
  always_comb begin
    w_err_new = '0;
    case (r_state)
      StWait:  w_err_new[ErrInitSeq] = w_nonnop;
      StPre:   w_err_new[ErrInitSeq] = w_nonnop && !((w_cmd == CmdPre) && w_a10);
      StAref:  w_err_new[ErrInitSeq] = w_nonnop && (w_cmd != CmdAref);
      StMrs:   w_err_new[ErrInitSeq] = w_nonnop && (w_cmd != CmdMrs);
      default: ;
    endcase
    if (w_nonnop && (r_tmr != '0)) begin
      case (r_tmr_src)
        TmrRp:   w_err_new[ErrTrp]  = 1'b1;
        TmrRfc:  w_err_new[ErrTrfc] = 1'b1;
        TmrMrd:  w_err_new[ErrTmrd] = 1'b1;
        default: ;
      endcase
    end
    // Fires only on the step into AREF_MAX; the interval counter then holds there.
    if ((r_state == StRun) && (w_cmd != CmdAref) && (r_aref_int == AIntW'(AREF_MAX - 1))) begin
      w_err_new[ErrArefLate] = 1'b1;
    end
`ifdef SDRAM_MON_BANK_CHK_EN
    w_err_new[ErrBank] = w_bank_viol;
`endif
  end

  // A bit being cleared this cycle counts as "new" again, so set-beats-clear also pulses.
  always_comb begin
    w_err_rise = w_err_new & (i_err_clr ? {ErrW{1'b1}} : ~r_err_vec);
  end

  // Init sequence FSM with its registered outputs.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state     <= StWait;
      r_wait      <= '0;
      r_init_aref <= '0;
      r_mode_reg  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        StWait: begin
          if (r_wait == WaitW'(INIT_WAIT - 1)) begin
            r_state <= StPre;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StPre: begin
          if ((w_cmd == CmdPre) && w_a10) begin
            r_state <= StAref;
          end
        end
        StAref: begin
          if (w_cmd == CmdAref) begin
            if (r_init_aref == ArW'(INIT_AREF - 1)) begin
              r_state <= StMrs;
            end else begin
              r_init_aref <= r_init_aref + ArW'(1);
            end
          end
        end
        StMrs: begin
          if (w_cmd == CmdMrs) begin
            r_mode_reg  <= i_sdram.sdram_addr;
            r_init_done <= 1'b1;
            r_state     <= StRun;
          end
        end
        default: ;
      endcase
    end
  end

  // Shared post-command timer; a new PRE/AREF/MRS always reloads it, legal or not.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_tmr     <= '0;
      r_tmr_src <= TmrNone;
    end else begin
      case (w_cmd)
        CmdPre: begin
          r_tmr     <= TmrW'(T_RP - 1);
          r_tmr_src <= TmrRp;
        end
        CmdAref: begin
          r_tmr     <= TmrW'(T_RFC - 1);
          r_tmr_src <= TmrRfc;
        end
        CmdMrs: begin
          r_tmr     <= TmrW'(T_MRD - 1);
          r_tmr_src <= TmrMrd;
        end
        default: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - TmrW'(1);
          end
        end
      endcase
    end
  end

  // Refresh interval and refresh count, RUN only.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_aref_int <= '0;
      r_aref_cnt <= '0;
    end else begin
      if (r_state == StRun) begin
        if (w_cmd == CmdAref) begin
          r_aref_int <= '0;
        end else if (r_aref_int != AIntW'(AREF_MAX)) begin
          r_aref_int <= r_aref_int + AIntW'(1);
        end
      end
      if (i_err_clr) begin
        r_aref_cnt <= '0;
      end else if ((r_state == StRun) && (w_cmd == CmdAref) && (r_aref_cnt != 16'hFFFF)) begin
        r_aref_cnt <= r_aref_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_err_vec   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_vec   <= (i_err_clr ? {ErrW{1'b0}} : r_err_vec) | w_err_new;
      r_err_pulse <= |w_err_rise;
    end
  end

  assign o_init_done = r_init_done;
  assign o_mode_reg  = r_mode_reg;
  assign o_aref_cnt  = r_aref_cnt;
  assign o_err_vec   = r_err_vec;
  assign o_err_pulse = r_err_pulse;

endmodule

// File: tb/tb_sdram_cmd_mon.sv
// Directed bench for sdram_cmd_mon with default parameters. Commands are driven on the
// falling edge and outputs sampled on the following falling edge. Bank-check expectations
// follow SDRAM_MON_BANK_CHK_EN.
module tb_sdram_cmd_mon;

  localparam logic [3:0] CNop  = 4'b0111;
  localparam logic [3:0] CAct  = 4'b0011;
  localparam logic [3:0] CPre  = 4'b0010;
  localparam logic [3:0] CAref = 4'b0001;
  localparam logic [3:0] CMrs  = 4'b0000;

`ifdef SDRAM_MON_BANK_CHK_EN
  localparam logic [5:0] BankBit = 6'h20;
`else
  localparam logic [5:0] BankBit = 6'h00;
`endif

  logic        clk;
  logic        rst;
  logic        err_clr;
  logic        init_done;
  logic [12:0] mode_reg;
  logic [15:0] aref_cnt;
  logic [5:0]  err_vec;
  logic        err_pulse;

  int n_checks;
  int n_pass;
  int n_cyc;

  sdram_cmd_mon_if u_if ();

  sdram_cmd_mon u_dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_sdram     (u_if),
    .i_err_clr   (err_clr),
    .o_init_done (init_done),
    .o_mode_reg  (mode_reg),
    .o_aref_cnt  (aref_cnt),
    .o_err_vec   (err_vec),
    .o_err_pulse (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, n_cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n_cyc++;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr);
    u_if.sdram_cmd  = c;
    u_if.sdram_ba   = ba;
    u_if.sdram_addr = addr;
    tick();
    u_if.sdram_cmd  = CNop;
    u_if.sdram_ba   = 2'd0;
    u_if.sdram_addr = 13'd0;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  task automatic clr_tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst   = 1'b0;
    n_cyc = 0;
  endtask

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    n_cyc           = 0;
    rst             = 1'b1;
    err_clr         = 1'b0;
    u_if.sdram_cmd  = CNop;
    u_if.sdram_ba   = 2'd0;
    u_if.sdram_addr = 13'd0;
    repeat (3) @(negedge clk);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_err_vec",   32'(err_vec),   32'd0);
    check("rst_mode_reg",  32'(mode_reg),  32'd0);
    check("rst_aref_cnt",  32'(aref_cnt),  32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    release_rst();

    // Early AREF during the power-up wait.
    nop(100);
    issue(CAref, 2'd0, 13'd0);
    check("early_aref_err",   32'(err_vec),   32'h01);
    check("early_aref_pulse", 32'(err_pulse), 32'd1);
    tick();
    check("early_aref_pulse_off", 32'(err_pulse), 32'd0);
    clr_tick();
    check("early_aref_clr", 32'(err_vec), 32'd0);

    // Legal init: PRE exactly at cycle INIT_WAIT, 2 AREF, MRS.
    nop(20000 - n_cyc);
    check("wait_no_done", 32'(init_done), 32'd0);
    issue(CPre, 2'd0, 13'h0400);
    nop(7);
    issue(CAref, 2'd0, 13'd0);
    nop(7);
    issue(CAref, 2'd0, 13'd0);
    nop(7);
    check("pre_mrs_no_done", 32'(init_done), 32'd0);
    issue(CMrs, 2'd0, 13'h0032);
    check("init_done",     32'(init_done), 32'd1);
    check("init_mode_reg", 32'(mode_reg),  32'h0032);
    check("init_err_vec",  32'(err_vec),   32'd0);
    check("init_aref_cnt", 32'(aref_cnt),  32'd0);
    nop(2);
    issue(CAref, 2'd0, 13'd0);
    check("tmrd_edge_err", 32'(err_vec),  32'd0);
    check("run_aref_cnt1", 32'(aref_cnt), 32'd1);

    // tRP: legal at +2, violation at +1.
    nop(7);
    issue(CPre, 2'd0, 13'd0);
    nop(1);
    issue(CAct, 2'd0, 13'd0);
    check("trp_edge_err", 32'(err_vec), 32'd0);
    issue(CPre, 2'd0, 13'h0400);
    issue(CAct, 2'd0, 13'd0);
    check("trp_err",   32'(err_vec),   32'h02);
    check("trp_pulse", 32'(err_pulse), 32'd1);
    tick();
    check("trp_pulse_off", 32'(err_pulse), 32'd0);
    check("trp_sticky",    32'(err_vec),   32'h02);
    issue(CPre, 2'd0, 13'h0400);
    clr_tick();
    check("trp_clr", 32'(err_vec), 32'd0);

    // Bank tracking: double ACT, then close one bank and refresh.
    issue(CAct, 2'd1, 13'd0);
    issue(CAct, 2'd1, 13'd0);
    check("bank_dbl_act", 32'(err_vec), 32'(BankBit));
    issue(CPre, 2'd1, 13'd0);
    clr_tick();
    issue(CAref, 2'd0, 13'd0);
    check("bank_aref_ok",  32'(err_vec),  32'd0);
    check("bank_aref_cnt", 32'(aref_cnt), 32'd1);

    // Refresh interval: late at the 750th cycle after the last AREF.
    nop(749);
    check("aref_749", 32'(err_vec), 32'd0);
    nop(1);
    check("aref_late",       32'(err_vec),   32'h10);
    check("aref_late_pulse", 32'(err_pulse), 32'd1);
    nop(1);
    check("aref_late_pulse_off", 32'(err_pulse), 32'd0);
    clr_tick();
    nop(10);
    check("aref_hold_no_refire", 32'(err_vec), 32'd0);
    issue(CAref, 2'd0, 13'd0);
    nop(699);
    issue(CAref, 2'd0, 13'd0);
    nop(699);
    issue(CAref, 2'd0, 13'd0);
    nop(50);
    check("aref_700_gap", 32'(err_vec),  32'd0);
    check("aref_cnt3",    32'(aref_cnt), 32'd3);

    // Set tRP, tRFC, tMRD, aref_late (and bank), then clear.
    issue(CPre, 2'd0, 13'h0400);
    issue(CAct, 2'd0, 13'd0);
    nop(1);
    issue(CAref, 2'd0, 13'd0);
    issue(CAct, 2'd0, 13'd0);
    issue(CMrs, 2'd0, 13'h01FF);
    issue(CAct, 2'd0, 13'd0);
    nop(760);
    check("all_err",       32'(err_vec),  32'(6'h1E | BankBit));
    check("all_aref_cnt",  32'(aref_cnt), 32'd4);
    check("run_mrs_no_cap", 32'(mode_reg), 32'h0032);
    clr_tick();
    check("all_clr_err",  32'(err_vec),  32'd0);
    check("all_clr_aref", 32'(aref_cnt), 32'd0);

    // Clear and a repeat tRP error in the same cycle: the error wins and pulses.
    issue(CPre, 2'd0, 13'h0400);
    issue(CAct, 2'd0, 13'd0);
    nop(1);
    issue(CPre, 2'd0, 13'h0400);
    err_clr = 1'b1;
    issue(CAct, 2'd0, 13'd0);
    err_clr = 1'b0;
    check("clr_vs_set_err",   32'(err_vec),   32'h02);
    check("clr_vs_set_pulse", 32'(err_pulse), 32'd1);

    // Reset from RUN.
    rst = 1'b1;
    #1;
    check("rst_run_done", 32'(init_done), 32'd0);
    check("rst_run_err",  32'(err_vec),   32'd0);
    check("rst_run_mode", 32'(mode_reg),  32'd0);
    release_rst();

    // Reset in the middle of the init AREF phase.
    nop(20000);
    issue(CPre, 2'd0, 13'h0400);
    nop(7);
    issue(CAref, 2'd0, 13'd0);
    nop(3);
    rst = 1'b1;
    #1;
    check("rst_aref_done", 32'(init_done), 32'd0);
    release_rst();

    // Restart must again need INIT_AREF refreshes: one AREF then MRS is out of sequence.
    nop(20000);
    issue(CPre, 2'd0, 13'h0400);
    check("restart_pre_ok", 32'(err_vec), 32'd0);
    nop(7);
    issue(CAref, 2'd0, 13'd0);
    nop(7);
    issue(CMrs, 2'd0, 13'h0123);
    check("restart_early_mrs_err",  32'(err_vec),   32'h01);
    check("restart_early_mrs_done", 32'(init_done), 32'd0);
    nop(7);
    issue(CAref, 2'd0, 13'd0);
    nop(7);
    issue(CMrs, 2'd0, 13'h0123);
    check("restart_done", 32'(init_done), 32'd1);
    check("restart_mode", 32'(mode_reg),  32'h0123);
    check("restart_err",  32'(err_vec),   32'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
